// File: rtl/btn_ctrl.sv
// Per-button input controller: 2-FF synchronizer, debounce and press/release pulse generation.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat scheduler (DELAY/REPEAT states).

module d_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

module btn_ctrl #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 250000,
  parameter int RPT_DELAY  = 10000000,
  parameter int RPT_PERIOD = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [63:0]      CNT_LIM = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

  localparam bit CNT_OK = (DB_CYCLES >= 1) && (RPT_DELAY >= 1) && (RPT_PERIOD >= 1) &&
                          (64'(DB_CYCLES) <= CNT_LIM) && (64'(RPT_DELAY) <= CNT_LIM) &&
                          (64'(RPT_PERIOD) <= CNT_LIM);
`else
  localparam bit CNT_OK = (DB_CYCLES >= 1) && (64'(DB_CYCLES) <= CNT_LIM);
`endif

  // A counter too narrow to reach its terminal value would never fire; flag it in simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) assert (CNT_OK);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic             s0;
    logic             s1;
    logic             level_q;
    logic [CNT_W-1:0] db_cnt;
    logic             mismatch;
    logic             db_done;
    logic             rise;
    logic             fall;
    logic             press_int;
    logic             press_q;
    logic             release_q;

    d_ff u_ff0 (.clk(clk), .rst_n(rst_n), .d(btn_raw[i]), .q(s0));
    d_ff u_ff1 (.clk(clk), .rst_n(rst_n), .d(s0),         .q(s1));

    assign mismatch = s1 ^ level_q;
    assign db_done  = mismatch && (db_cnt == DB_LAST);
    assign rise     = db_done & ~level_q;
    assign fall     = db_done & level_q;

    // The level only flips after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (!mismatch) begin
        db_cnt  <= '0;
      end else if (db_done) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt  <= db_cnt + CNT_W'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [1:0]       state;
    logic [CNT_W-1:0] rpt_cnt;
    logic             dly_hit;
    logic             per_hit;

    assign dly_hit   = (state == S_DELAY)  && (rpt_cnt == DLY_LAST);
    assign per_hit   = (state == S_REPEAT) && (rpt_cnt == PER_LAST);
    // A release landing on a repeat boundary suppresses that repeat.
    assign press_int = rise | (~fall & (dly_hit | per_hit));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= S_IDLE;
        rpt_cnt <= '0;
      end else if (fall) begin
        state   <= S_IDLE;
        rpt_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            rpt_cnt <= '0;
            if (rise) state <= S_DELAY;
          end
          S_DELAY: begin
            if (dly_hit) begin
              state   <= S_REPEAT;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
          end
          S_REPEAT: begin
            if (per_hit) rpt_cnt <= '0;
            else         rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
          default: begin
            state   <= S_IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
`else
    assign press_int = rise;
`endif

    // en only masks what leaves the block; the schedule keeps running underneath.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_int & en;
        release_q <= fall & en;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// Scoreboard bench for btn_ctrl: stimulus queues expected pulse events, a monitor pops and compares.
// Expected repeat pulses are added when BTN_AUTOREPEAT_EN is defined.

module tb_btn_ctrl;

  localparam int N_BTN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  always #5 clk = ~clk;

  btn_ctrl #(
    .N_BTN(N_BTN), .DB_CYCLES(4), .RPT_DELAY(10), .RPT_PERIOD(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .en(en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] level;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushEvent(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] l);
    sb.push_back(exp_t'{c, p, r, l});
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] raw);
    rst_n   = r;
    en      = e;
    btn_raw = raw;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Any pulse on either output is one observed event; it must match the head of the scoreboard.
  always @(negedge clk) begin
    if ((btn_press | btn_release) !== 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL event: unexpected at cyc %0d press=%b release=%b level=%b",
                 cyc, btn_press, btn_release, btn_level);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || btn_press !== mon_e.press || btn_release !== mon_e.rel ||
            btn_level !== mon_e.level) begin
          miscompares++;
          $display("[TB] FAIL event: got cyc=%0d press=%b release=%b level=%b, want cyc=%0d press=%b release=%b level=%b",
                   cyc, btn_press, btn_release, btn_level,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.level);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held with both buttons pressed: nothing may leak out.
    applyStimulus(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_outputs", {26'd0, btn_level, btn_press, btn_release}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(10);
    checkOutput("idle_level", {30'd0, btn_level}, 32'd0);

    // Clean press of btn0 held 30 cycles.
    k = cyc;
    applyStimulus(1'b1, 1'b1, 2'b01);
    pushEvent(k + 6, 2'b01, 2'b00, 2'b01);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = k + 16; t < k + 36; t += 3) pushEvent(t, 2'b01, 2'b00, 2'b01);
`endif
    pushEvent(k + 36, 2'b00, 2'b01, 2'b00);
    waitCycles(30);
    checkOutput("held_level", {30'd0, btn_level}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(12);

    // Three-cycle glitch on btn1 must be rejected.
    applyStimulus(1'b1, 1'b1, 2'b10);
    waitCycles(3);
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(4);
    checkOutput("glitch_level", {30'd0, btn_level}, 32'd0);
    waitCycles(6);

    // Release lands on the cycle the first repeat would fire.
    k = cyc;
    applyStimulus(1'b1, 1'b1, 2'b01);
    pushEvent(k + 6,  2'b01, 2'b00, 2'b01);
    pushEvent(k + 16, 2'b00, 2'b01, 2'b00);
    waitCycles(10);
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(14);

    // en low for 8 cycles mid-hold masks three repeats, schedule continues.
    k = cyc;
    applyStimulus(1'b1, 1'b1, 2'b01);
    pushEvent(k + 6, 2'b01, 2'b00, 2'b01);
`ifdef BTN_AUTOREPEAT_EN
    pushEvent(k + 25, 2'b01, 2'b00, 2'b01);
    pushEvent(k + 28, 2'b01, 2'b00, 2'b01);
    pushEvent(k + 31, 2'b01, 2'b00, 2'b01);
`endif
    pushEvent(k + 32, 2'b00, 2'b01, 2'b00);
    waitCycles(14);
    applyStimulus(1'b1, 1'b0, 2'b01);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1, 2'b01);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(12);

    // en low across the initial press of btn1: level tracks, pulse is masked.
    k = cyc;
    applyStimulus(1'b1, 1'b0, 2'b10);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1, 2'b10);
    checkOutput("masked_level", {30'd0, btn_level}, 32'd2);
    waitCycles(2);
    applyStimulus(1'b1, 1'b1, 2'b00);
    pushEvent(k + 16, 2'b00, 2'b10, 2'b00);
    waitCycles(12);

    // Both buttons together, then a one-cycle reset mid-hold.
    k = cyc;
    applyStimulus(1'b1, 1'b1, 2'b11);
    pushEvent(k + 6, 2'b11, 2'b00, 2'b11);
    waitCycles(8);
    applyStimulus(1'b0, 1'b1, 2'b11);
    waitCycles(1);
    checkOutput("midhold_reset", {26'd0, btn_level, btn_press, btn_release}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b11);
    pushEvent(k + 15, 2'b11, 2'b00, 2'b11);
    pushEvent(k + 23, 2'b00, 2'b11, 2'b00);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1, 2'b00);
    waitCycles(12);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
